// File: rtl/corelet_ctrl_if.sv
// Control bundle between the corelet sequencer and its environment: host
// pass parameters, OFIFO status, and every corelet/memory control strobe.
interface corelet_ctrl_if #(
  parameter int len_bw  = 6,
  parameter int kij_bw  = 4,
  parameter int addr_bw = 11
);
  logic               start;
  logic [kij_bw-1:0]  nkij;
  logic [len_bw-1:0]  len;
  logic [addr_bw-1:0] w_base;
  logic [addr_bw-1:0] x_base;
  logic               ofifo_valid;

  logic               xmem_cen;
  logic [addr_bw-1:0] xmem_addr;
  logic               pmem_wen;
  logic               pmem_ren;
  logic [addr_bw-1:0] pmem_addr;
  logic [1:0]         inst;
  logic               l0_wr;
  logic               l0_rd;
  logic               ofifo_rd;
  logic               accum;
  logic               relu_valid;
  logic               busy;
  logic               done;

  modport master (
    input  start, nkij, len, w_base, x_base, ofifo_valid,
    output xmem_cen, xmem_addr, pmem_wen, pmem_ren, pmem_addr, inst,
           l0_wr, l0_rd, ofifo_rd, accum, relu_valid, busy, done
  );

  modport slave (
    output start, nkij, len, w_base, x_base, ofifo_valid,
    input  xmem_cen, xmem_addr, pmem_wen, pmem_ren, pmem_addr, inst,
           l0_wr, l0_rd, ofifo_rd, accum, relu_valid, busy, done
  );
endinterface

// File: rtl/corelet_ctrl.sv
// Corelet pass sequencer: per kernel position load/shift/flush weights,
// load/execute activations, drain OFIFO to psum memory, then accumulate+ReLU.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_bw  = 6,
  parameter int kij_bw  = 4,
  parameter int addr_bw = 11
) (
  input logic            clk,
  input logic            reset,
  corelet_ctrl_if.master bus
);
  typedef logic [addr_bw-1:0] addrT;
  typedef logic [len_bw-1:0]  lenT;
  typedef logic [kij_bw-1:0]  kijT;
  typedef logic [7:0]         cntT;

  typedef enum logic [3:0] {
    IDLE, W_LOAD, W_SHIFT, W_FLUSH, X_LOAD, X_EXEC, O_DRAIN, ACC, DONE
  } stateT;

  localparam cntT ROW_LAST   = cntT'(row - 1);
  localparam cntT FLUSH_LAST = cntT'(row + col - 1);

  stateT stateQ, stateD;
  cntT   iQ, iD;
  kijT   kQ, kD, nkijQ, nkijD;
  lenT   oQ, oD, rdCntQ, rdCntD, lenQ, lenD;
  addrT  wPtrQ, wPtrD, xBaseQ, xBaseD, pBaseQ, pBaseD, accAddrQ, accAddrD;

  logic       xmemCenQ, xmemCenD, pmemWenQ, pmemWenD, pmemRenQ, pmemRenD;
  addrT       xmemAddrQ, xmemAddrD, pmemAddrQ, pmemAddrD;
  logic [1:0] instQ, instD;
  logic       l0WrQ, l0WrD, l0RdQ, l0RdD, accumQ, accumD;
  logic       reluQ, reluD, busyQ, busyD, doneQ, doneD;
  logic       ofifoRd;
  cntT        lenLast, accLast;

  // Transitions first, then every registered output is decoded from the
  // next-state values so it lines up with the cycle that state occupies.
  always_comb begin
    stateD   = stateQ;
    iD       = iQ + cntT'(1);
    kD       = kQ;
    oD       = oQ;
    rdCntD   = rdCntQ;
    nkijD    = nkijQ;
    lenD     = lenQ;
    wPtrD    = wPtrQ;
    xBaseD   = xBaseQ;
    pBaseD   = pBaseQ;
    accAddrD = accAddrQ;
    lenLast  = cntT'(lenQ) - cntT'(1);
    accLast  = cntT'(nkijQ) + cntT'(2);
    ofifoRd  = (stateQ == O_DRAIN) && (rdCntQ != lenQ) && bus.ofifo_valid;

    case (stateQ)
      IDLE: begin
        iD = '0;
        if (bus.start) begin
          stateD = W_LOAD;
          kD     = '0;
          nkijD  = bus.nkij;
          lenD   = bus.len;
          wPtrD  = bus.w_base;
          xBaseD = bus.x_base;
          pBaseD = '0;
        end
      end
      W_LOAD:  if (iQ == ROW_LAST)   begin stateD = W_SHIFT; iD = '0; end
      W_SHIFT: if (iQ == ROW_LAST)   begin stateD = W_FLUSH; iD = '0; end
      W_FLUSH: if (iQ == FLUSH_LAST) begin stateD = X_LOAD;  iD = '0; end
      X_LOAD:  if (iQ == lenLast)    begin stateD = X_EXEC;  iD = '0; end
      X_EXEC: begin
        if (iQ == lenLast) begin
          stateD = O_DRAIN;
          iD     = '0;
          rdCntD = '0;
        end
      end
      O_DRAIN: begin
        iD = '0;
        if (ofifoRd) rdCntD = rdCntQ + lenT'(1);
        // All rows read means this cycle carries the final delayed write.
        if (rdCntQ == lenQ) begin
          if (kQ + kijT'(1) == nkijQ) begin
            stateD   = ACC;
            oD       = '0;
            accAddrD = '0;
          end else begin
            stateD = W_LOAD;
            kD     = kQ + kijT'(1);
            wPtrD  = wPtrQ + addrT'(row);
            pBaseD = pBaseQ + addrT'(lenQ);
          end
        end
      end
      ACC: begin
        accAddrD = accAddrQ + addrT'(lenQ);
        if (iQ == accLast) begin
          iD       = '0;
          accAddrD = addrT'(oQ) + addrT'(1);
          if (oQ == lenQ - lenT'(1)) stateD = DONE;
          else oD = oQ + lenT'(1);
        end
      end
      DONE: begin
        stateD = IDLE;
        iD     = '0;
      end
      default: begin
        stateD = IDLE;
        iD     = '0;
      end
    endcase

    xmemCenD  = (stateD == W_LOAD) || (stateD == X_LOAD);
    xmemAddrD = '0;
    if (stateD == W_LOAD)      xmemAddrD = wPtrD + addrT'(iD);
    else if (stateD == X_LOAD) xmemAddrD = xBaseD + addrT'(iD);
    l0WrD     = xmemCenQ;
    l0RdD     = (stateD == W_SHIFT) || (stateD == X_EXEC);
    instD     = (stateD == W_SHIFT) ? 2'b01 : (stateD == X_EXEC) ? 2'b10 : 2'b00;
    pmemWenD  = ofifoRd;
    pmemRenD  = (stateD == ACC) && (iD < cntT'(nkijD));
    pmemAddrD = '0;
    if (pmemWenD)      pmemAddrD = pBaseQ + addrT'(rdCntQ);
    else if (pmemRenD) pmemAddrD = accAddrD;
    accumD    = pmemRenQ;
    reluD     = (stateD == ACC) && (iD == cntT'(nkijD) + cntT'(1));
    busyD     = (stateD != IDLE) && (stateD != DONE);
    doneD     = (stateD == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= IDLE;
      iQ        <= '0;
      kQ        <= '0;
      oQ        <= '0;
      rdCntQ    <= '0;
      nkijQ     <= '0;
      lenQ      <= '0;
      wPtrQ     <= '0;
      xBaseQ    <= '0;
      pBaseQ    <= '0;
      accAddrQ  <= '0;
      xmemCenQ  <= 1'b0;
      xmemAddrQ <= '0;
      pmemWenQ  <= 1'b0;
      pmemRenQ  <= 1'b0;
      pmemAddrQ <= '0;
      instQ     <= 2'b00;
      l0WrQ     <= 1'b0;
      l0RdQ     <= 1'b0;
      accumQ    <= 1'b0;
      reluQ     <= 1'b0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      iQ        <= iD;
      kQ        <= kD;
      oQ        <= oD;
      rdCntQ    <= rdCntD;
      nkijQ     <= nkijD;
      lenQ      <= lenD;
      wPtrQ     <= wPtrD;
      xBaseQ    <= xBaseD;
      pBaseQ    <= pBaseD;
      accAddrQ  <= accAddrD;
      xmemCenQ  <= xmemCenD;
      xmemAddrQ <= xmemAddrD;
      pmemWenQ  <= pmemWenD;
      pmemRenQ  <= pmemRenD;
      pmemAddrQ <= pmemAddrD;
      instQ     <= instD;
      l0WrQ     <= l0WrD;
      l0RdQ     <= l0RdD;
      accumQ    <= accumD;
      reluQ     <= reluD;
      busyQ     <= busyD;
      doneQ     <= doneD;
    end
  end

  assign bus.xmem_cen   = xmemCenQ;
  assign bus.xmem_addr  = xmemAddrQ;
  assign bus.pmem_wen   = pmemWenQ;
  assign bus.pmem_ren   = pmemRenQ;
  assign bus.pmem_addr  = pmemAddrQ;
  assign bus.inst       = instQ;
  assign bus.l0_wr      = l0WrQ;
  assign bus.l0_rd      = l0RdQ;
  assign bus.ofifo_rd   = ofifoRd;
  assign bus.accum      = accumQ;
  assign bus.relu_valid = reluQ;
  assign bus.busy       = busyQ;
  assign bus.done       = doneQ;
endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench for corelet_ctrl: a model pushes expected memory addresses
// and inst codes per pass; a negedge monitor pops and compares them.
module tb_corelet_ctrl;
  localparam int ROW = 8, COL = 8, LEN_BW = 6, KIJ_BW = 4, ADDR_BW = 11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [10:0] expXmem[$];
  logic [10:0] expPwr[$];
  logic [10:0] expPrd[$];
  logic [1:0]  expInst[$];

  logic monOn = 1'b0;
  logic prevXmem = 1'b0, prevRen = 1'b0, prevOrd = 1'b0;
  int   accSinceRelu = 0, reluCount = 0, doneCount = 0, rdCount = 0, expNkij = 0;

  always #5 clk = ~clk;

  corelet_ctrl_if #(.len_bw(LEN_BW), .kij_bw(KIJ_BW), .addr_bw(ADDR_BW)) bus ();

  corelet_ctrl #(.row(ROW), .col(COL), .len_bw(LEN_BW), .kij_bw(KIJ_BW), .addr_bw(ADDR_BW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [33:0] outVec();
    return {bus.xmem_cen, bus.xmem_addr, bus.pmem_wen, bus.pmem_ren, bus.pmem_addr, bus.inst,
            bus.l0_wr, bus.l0_rd, bus.ofifo_rd, bus.accum, bus.relu_valid, bus.busy, bus.done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitorLoop();
    logic [10:0] e;
    logic [1:0]  ei;
    forever begin
      @(negedge clk);
      if (monOn) begin
        checks++;
        if ((int'(bus.xmem_cen) + int'(bus.pmem_wen) + int'(bus.pmem_ren)) > 1) begin
          errors++;
          $display("[TB] FAIL mem_exclusive got cen=%0b wen=%0b ren=%0b want at most one", bus.xmem_cen, bus.pmem_wen, bus.pmem_ren);
        end
        checks++;
        if (bus.l0_wr !== prevXmem) begin
          errors++;
          $display("[TB] FAIL l0_wr_delay got %0b want %0b", bus.l0_wr, prevXmem);
        end
        checks++;
        if (bus.accum !== prevRen) begin
          errors++;
          $display("[TB] FAIL accum_delay got %0b want %0b", bus.accum, prevRen);
        end
        checks++;
        if (bus.pmem_wen !== prevOrd) begin
          errors++;
          $display("[TB] FAIL pmem_wen_delay got %0b want %0b", bus.pmem_wen, prevOrd);
        end
        if (bus.xmem_cen) begin
          checks++;
          if (expXmem.size() == 0) begin
            errors++;
            $display("[TB] FAIL xmem_extra got addr %0d want no access", bus.xmem_addr);
          end else begin
            e = expXmem.pop_front();
            if (bus.xmem_addr !== e) begin
              errors++;
              $display("[TB] FAIL xmem_addr got %0d want %0d", bus.xmem_addr, e);
            end
          end
        end
        if (bus.pmem_wen) begin
          checks++;
          if (expPwr.size() == 0) begin
            errors++;
            $display("[TB] FAIL pmem_wr_extra got addr %0d want no write", bus.pmem_addr);
          end else begin
            e = expPwr.pop_front();
            if (bus.pmem_addr !== e) begin
              errors++;
              $display("[TB] FAIL pmem_wr_addr got %0d want %0d", bus.pmem_addr, e);
            end
          end
        end
        if (bus.pmem_ren) begin
          checks++;
          if (expPrd.size() == 0) begin
            errors++;
            $display("[TB] FAIL pmem_rd_extra got addr %0d want no read", bus.pmem_addr);
          end else begin
            e = expPrd.pop_front();
            if (bus.pmem_addr !== e) begin
              errors++;
              $display("[TB] FAIL pmem_rd_addr got %0d want %0d", bus.pmem_addr, e);
            end
          end
        end
        if (bus.inst != 2'b00) begin
          checks++;
          if (expInst.size() == 0) begin
            errors++;
            $display("[TB] FAIL inst_extra got %0b want 00", bus.inst);
          end else begin
            ei = expInst.pop_front();
            if (bus.inst !== ei) begin
              errors++;
              $display("[TB] FAIL inst_seq got %0b want %0b", bus.inst, ei);
            end
          end
        end
        if (bus.accum) accSinceRelu++;
        if (bus.relu_valid) begin
          checks++;
          if (accSinceRelu != expNkij) begin
            errors++;
            $display("[TB] FAIL accum_per_relu got %0d want %0d", accSinceRelu, expNkij);
          end
          accSinceRelu = 0;
          reluCount++;
        end
        if (bus.ofifo_rd) rdCount++;
        if (bus.done) doneCount++;
      end
      prevXmem = bus.xmem_cen;
      prevRen  = bus.pmem_ren;
      prevOrd  = bus.ofifo_rd;
    end
  endtask

  task automatic pushPass(input int nk, input int ln, input int wb, input int xb);
    for (int k = 0; k < nk; k++) begin
      for (int i = 0; i < ROW; i++) begin
        expXmem.push_back(11'(wb + k * ROW + i));
        expInst.push_back(2'b01);
      end
      for (int i = 0; i < ln; i++) begin
        expXmem.push_back(11'(xb + i));
        expInst.push_back(2'b10);
      end
      for (int j = 0; j < ln; j++) expPwr.push_back(11'(k * ln + j));
    end
    for (int o = 0; o < ln; o++)
      for (int m = 0; m < nk; m++) expPrd.push_back(11'(m * ln + o));
    expNkij = nk;
    accSinceRelu = 0;
    reluCount = 0;
    doneCount = 0;
    rdCount = 0;
  endtask

  task automatic startPass(input int nk, input int ln, input int wb, input int xb);
    bus.nkij   = KIJ_BW'(nk);
    bus.len    = LEN_BW'(ln);
    bus.w_base = ADDR_BW'(wb);
    bus.x_base = ADDR_BW'(xb);
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    int c = 1;
    while (!bus.done && c < 5000) begin
      step();
      c++;
    end
    if (!bus.done) begin
      errors++;
      $display("[TB] FAIL done_timeout got no done after %0d cycles want done", c);
    end
    cyc = c;
  endtask

  task automatic endPass(input int cyc, input int expCyc, input int ln);
    checks++;
    if (cyc != expCyc) begin
      errors++;
      $display("[TB] FAIL pass_cycles got %0d want %0d", cyc, expCyc);
    end
    checks++;
    if (reluCount != ln) begin
      errors++;
      $display("[TB] FAIL relu_count got %0d want %0d", reluCount, ln);
    end
    checks++;
    if (doneCount != 1) begin
      errors++;
      $display("[TB] FAIL done_count got %0d want 1", doneCount);
    end
    checks++;
    if ((expXmem.size() + expPwr.size() + expPrd.size() + expInst.size()) != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_left got x%0d w%0d r%0d i%0d want all 0",
               expXmem.size(), expPwr.size(), expPrd.size(), expInst.size());
    end
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL post_done got busy=%0b done=%0b want 0 0", bus.busy, bus.done);
    end
  endtask

  function automatic int passCycles(input int nk, input int ln);
    return 1 + nk * (3 * ROW + COL + 3 * ln + 1) + ln * (nk + 3);
  endfunction

  task automatic test_reset();
    int n = 0;
    monOn = 1'b0;
    reset = 1'b1;
    step();
    step();
    checks++;
    if (outVec() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h want 0", outVec());
    end
    reset = 1'b0;
    step();
    startPass(1, 4, 0, 16);
    while (bus.inst != 2'b10 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (bus.inst != 2'b10) begin
      errors++;
      $display("[TB] FAIL reach_exec got inst %0b want 10", bus.inst);
    end
    reset = 1'b1;
    step();
    checks++;
    if (outVec() !== '0) begin
      errors++;
      $display("[TB] FAIL midpass_reset got %h want 0", outVec());
    end
    step();
    step();
    reset = 1'b0;
    step();
    step();
    step();
    checks++;
    if ({bus.busy, bus.xmem_cen, bus.inst} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got busy=%0b cen=%0b inst=%0b want 0", bus.busy, bus.xmem_cen, bus.inst);
    end
  endtask

  task automatic test_basic();
    int cyc;
    monOn = 1'b1;
    pushPass(1, 4, 0, 16);
    startPass(1, 4, 0, 16);
    checks++;
    if ({bus.busy, bus.xmem_cen} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL start_latency got busy=%0b cen=%0b want 1 1", bus.busy, bus.xmem_cen);
    end
    waitDone(cyc);
    step();
    endPass(cyc, 62, 4);
  endtask

  task automatic test_large();
    int cyc;
    pushPass(9, 16, 40, 300);
    startPass(9, 16, 40, 300);
    waitDone(cyc);
    step();
    endPass(cyc, passCycles(9, 16), 16);
  endtask

  task automatic test_ofifo_stall();
    int cyc;
    pushPass(2, 6, 5, 700);
    startPass(2, 6, 5, 700);
    fork
      waitDone(cyc);
      begin
        int n = 0;
        while (rdCount < 2 && n < 2000) begin
          step();
          n++;
        end
        checks++;
        if (rdCount != 2) begin
          errors++;
          $display("[TB] FAIL stall_trigger got %0d reads want 2", rdCount);
        end
        bus.ofifo_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          checks++;
          if (bus.ofifo_rd !== 1'b0 || (s > 0 && bus.pmem_wen !== 1'b0)) begin
            errors++;
            $display("[TB] FAIL stall_quiet got rd=%0b wen=%0b want 0 at stall cycle %0d", bus.ofifo_rd, bus.pmem_wen, s);
          end
          step();
        end
        bus.ofifo_valid = 1'b1;
      end
    join
    step();
    endPass(cyc, passCycles(2, 6) + 5, 6);
  endtask

  task automatic test_start_ignored();
    int c = 1;
    pushPass(2, 3, 64, 128);
    startPass(2, 3, 64, 128);
    while (!bus.done && c < 5000) begin
      bus.start = (c == 10);
      if (c == 10) begin
        bus.nkij   = 4'd5;
        bus.len    = 6'd9;
        bus.w_base = 11'd999;
      end
      step();
      c++;
    end
    bus.start = 1'b0;
    checks++;
    if (!bus.done) begin
      errors++;
      $display("[TB] FAIL done_timeout got no done after %0d cycles want done", c);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    endPass(c, passCycles(2, 3), 3);
    repeat (5) step();
    checks++;
    if (bus.busy !== 1'b0 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL start_in_done got busy=%0b dones=%0d want 0 1", bus.busy, doneCount);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    pushPass(3, 5, 2040, 2045);
    startPass(3, 5, 2040, 2045);
    waitDone(cyc);
    step();
    endPass(cyc, passCycles(3, 5), 5);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.nkij        = '0;
    bus.len         = '0;
    bus.w_base      = '0;
    bus.x_base      = '0;
    bus.ofifo_valid = 1'b1;
    fork
      monitorLoop();
    join_none
    $display("[TB] reset");
    test_reset();
    $display("[TB] basic pass");
    test_basic();
    $display("[TB] nkij=9 len=16");
    test_large();
    $display("[TB] ofifo stall");
    test_ofifo_stall();
    $display("[TB] start while busy");
    test_start_ignored();
    $display("[TB] address wrap pass");
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/corelet_ctrl.md
# corelet_ctrl

Sequencing controller for one corelet (L0 input FIFO, 8x8 MAC array, OFIFO, per-column SFU) plus its shared single-port memories. On a `start` pulse it runs a full convolution pass: for each of `nkij` kernel positions it loads kernel rows into L0, shifts them into the array, streams `len` activation vectors, and drains OFIFO partial sums into psum memory. It then reads the partial sums back through the SFUs to accumulate and ReLU each output vector. It sits between the top-level testbench/host and the corelet, and drives every corelet control input.

## Interface
Parameters:
- `row`, 8: L0 lanes / MAC rows (kernel rows loaded per kij)
- `col`, 8: MAC columns (OFIFO width in psums)
- `len_bw`, 6: width of activation-count fields (max 63 vectors)
- `kij_bw`, 4: width of kernel-position count (max 15)
- `addr_bw`, 11: memory address width

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle pulse; sampled only in IDLE
- `nkij` in kij_bw: number of kernel positions, ≥1, latched at start
- `len` in len_bw: activation vectors per kij (= outputs), ≥1, latched at start
- `w_base`, `x_base` in addr_bw: kernel / activation base addresses in xmem, latched at start
- `ofifo_valid` in 1: from corelet, OFIFO holds a full row
- `xmem_cen` out 1: xmem read enable (active-high); data valid next cycle
- `xmem_addr` out addr_bw
- `pmem_wen` / `pmem_ren` out 1: psum memory write / read enable; read data valid next cycle
- `pmem_addr` out addr_bw
- `inst` out 2: corelet inst; 01 = kernel load, 10 = execute, 00 = idle
- `l0_wr`, `l0_rd`, `ofifo_rd`, `accum`, `relu_valid` out 1: corelet strobes
- `busy` out 1: high from the cycle after start until done
- `done` out 1: one-cycle pulse at end of pass

## Operation
- States: IDLE → W_LOAD → W_SHIFT → W_FLUSH → X_LOAD → X_EXEC → O_DRAIN → (next kij: W_LOAD, else ACC) → ACC → DONE → IDLE.
- Counters: `k` (kij index), `i` (step within state), `o` (output index in ACC).
- W_LOAD, `row` cycles: `xmem_cen` = 1, `xmem_addr` = w_base + k·row + i. `l0_wr` is the 1-cycle-delayed copy of `xmem_cen`, so the last write lands in the first cycle of W_SHIFT.
- W_SHIFT, `row` cycles: `l0_rd` = 1, `inst` = 01.
- W_FLUSH, `row`+`col` cycles: all strobes 0; lets the kernel settle in the array.
- X_LOAD, `len` cycles: `xmem_cen` = 1, `xmem_addr` = x_base + i; `l0_wr` delayed by 1 as above.
- X_EXEC, `len` cycles: `l0_rd` = 1, `inst` = 10.
- O_DRAIN:
  - `ofifo_rd` = `ofifo_valid`.
  - `pmem_wen` = `ofifo_rd` delayed 1 cycle, at `pmem_addr` = k·len + count of rows already written.
  - Exit after `len` writes. No timeout: the state waits indefinitely on `ofifo_valid`.
- ACC, for o = 0..len-1:
  - Issue `nkij` reads, `pmem_ren` = 1 at `pmem_addr` = m·len + o for m = 0..nkij-1. `accum` = `pmem_ren` delayed 1 cycle.
  - In the cycle after the last `accum`, pulse `relu_valid` = 1 for one cycle.
  - One idle gap cycle follows before the next o.
- DONE: `done` = 1 for one cycle, `busy` = 0, return to IDLE.
- All address arithmetic is unsigned, truncated to addr_bw; wrap is not detected.
- `start` while busy is ignored.
- Only one of xmem_cen / pmem_wen / pmem_ren is ever high in a cycle.

## Timing
- Reset: state = IDLE, counters = 0, and every output 0 (`inst` = 00, `busy` = 0, `done` = 0) in the cycle after reset is sampled high.
- Reset mid-pass aborts immediately; delayed strobes (`l0_wr`, `pmem_wen`, `accum`) are also cleared, with no trailing pulse.
- start → first `xmem_cen` on the next cycle; `busy` is high in that same cycle.
- Per-kij length with ofifo_valid always high: 3·row + col + 2·len + len + 1 cycles (the trailing 1 is the O_DRAIN write delay).
- ACC length: len·(nkij + 3) cycles. DONE: 1 cycle.
- `ofifo_valid` dropping mid-drain stalls with no read and no write. Resuming continues at the next address.

## Test plan
- Reset: hold reset 3 cycles mid-X_EXEC → all outputs 0 next cycle, IDLE; a new start runs the full pass cleanly.
- nkij=1, len=4, w_base=0, x_base=16, ofifo_valid=1:
  - xmem_addr 0..7 then 16..19.
  - inst=01 ×8 and inst=10 ×4.
  - pmem writes at 0..3.
  - accum 1 per output, 4 relu_valid pulses, done after exactly 1+(24+8+12+1)+16 cycles.
- nkij=9, len=16: ACC read addresses for o=3 are 3,19,35,…,131. Exactly 9 accum strobes precede each relu_valid.
- OFIFO stall: ofifo_valid low for 5 cycles after 2 rows → no ofifo_rd or pmem_wen during the stall; the remaining rows are written to addresses 2..len-1 with no gaps or duplicates.
- start asserted while busy and in DONE → ignored; the pass is unchanged and no second done pulse occurs.
- Exclusivity check over a full run: never more than one of xmem_cen/pmem_wen/pmem_ren high; l0_wr always equals xmem_cen delayed by 1.
